// File: rtl/ula_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ula_pkg : shared types and constants for the ULA register slave  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ula_pkg;

  localparam int DATA_W     = 16;
  localparam int OUT_W      = 32;
  localparam int NUM_REGS   = 4;
  localparam int MUL_CYCLES = 16;
  localparam int CNT_W      = 4;
  localparam int SEL_W      = 2;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_LOAD = 2'b11
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic [OUT_W-1:0] zext(input logic [DATA_W-1:0] v);
    return {{(OUT_W-DATA_W){1'b0}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ula_mul_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ula_mul_seq : 16x16 unsigned shift-add multiplier, 1 bit / cycle |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ula_mul_seq
  import ula_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [OUT_W-1:0]  product
);

  logic [OUT_W-1:0]  mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              done_q, done_d;

  // Bit 0 of the multiplier is consumed at the start edge, so the final
  // partial product lands 15 edges later and done is seen one cycle after.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = zext(a) << 1;
      mplier_d = b >> 1;
      acc_d    = b[0] ? zext(a) : '0;
      cnt_d    = CNT_W'(1);
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == MUL_LAST) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule
`default_nettype wire

// File: rtl/ula_reg_slave.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ula_reg_slave : 4x16 register file with ADD/SUB/LOAD and MUL ALU |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ula_reg_slave
  import ula_pkg::*;
(
  input  logic              clk_ula,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic [SEL_W-1:0]  reg_sel,
  input  logic [1:0]        instru,
  input  logic              valid_ula,
  output logic [OUT_W-1:0]  data_out,
  output logic              valid_out,
  output logic              busy,
  output logic              err
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              err_q, err_d;

  logic              mul_start;
  logic              mul_done;
  logic [OUT_W-1:0]  mul_product;
  logic [DATA_W-1:0] operand;
  opcode_e           op;

  assign operand = regs_q[reg_sel];
  assign op      = opcode_e'(instru);

  always_comb begin
    regs_d      = regs_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    err_d       = err_q;
    mul_start   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (valid_ula) begin
          unique case (op)
            OP_ADD: begin
              data_out_d  = zext(operand) + zext(A);
              valid_out_d = 1'b1;
            end
            OP_SUB: begin
              data_out_d  = zext(operand) - zext(A);
              valid_out_d = 1'b1;
            end
            OP_LOAD: begin
              regs_d[reg_sel] = A;
              data_out_d      = zext(A);
              valid_out_d     = 1'b1;
            end
            OP_MUL: begin
              mul_start = 1'b1;
              state_d   = ST_MUL;
              cnt_d     = '0;
            end
          endcase
        end
      end
      ST_MUL: begin
        // Any request seen while multiplying is dropped and flagged.
        if (valid_ula) begin
          err_d = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          valid_out_d = mul_done;
          if (mul_done) begin
            data_out_d = mul_product;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_ula) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      err_q       <= err_d;
    end
  end

  ula_mul_seq u_mul (
    .clk     (clk_ula),
    .rst     (rst),
    .start   (mul_start),
    .a       (operand),
    .b       (A),
    .done    (mul_done),
    .product (mul_product)
  );

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign busy      = (state_q == ST_MUL);
  assign err       = err_q;

endmodule
`default_nettype wire
